// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared defaults and FSM state encoding for the data-memory port arbiter
package dmem_arb_pkg;
   localparam int DEF_DBITS        = 16;
   localparam int DEF_ABITS        = 12;
   localparam int DEF_BURST_BITS   = 4;
   localparam int DEF_STARVE_LIMIT = 8;
   typedef enum logic {ST_IDLE, ST_BURST} state_t;
endpackage

// File: rtl/dmem_burst_ctr.sv
// dmem_burst_ctr: next-beat address and remaining-beat counter for loader bursts
module dmem_burst_ctr #(
   parameter int ABITS      = 12,
   parameter int BURST_BITS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic                  step,
   input  logic [ABITS-1:0]      base,
   input  logic [BURST_BITS-1:0] len,
   output logic [ABITS-1:0]      addr,
   output logic                  last
);
   logic [BURST_BITS-1:0] cnt;
   // beat 0 goes out directly from the request, so load primes the counter for beat 1
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         addr <= '0;
         cnt  <= '0;
      end else if (load) begin
         addr <= base + 1'b1;
         cnt  <= len - 1'b1;
      end else if (step) begin
         addr <= addr + 1'b1;
         cnt  <= cnt - 1'b1;
      end
   assign last = cnt == '0;
endmodule

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares the MemArray data port between CPU single beats and loader bursts (optional starvation guard: DMEM_ARB_STARVE_GUARD_EN)
module dmem_port_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int DBITS      = DEF_DBITS,
   parameter int ABITS      = DEF_ABITS,
   parameter int BURST_BITS = DEF_BURST_BITS
`ifdef DMEM_ARB_STARVE_GUARD_EN
   , parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
`endif
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic                  CREQ,
   input  logic                  CWE,
   input  logic [ABITS-1:0]      CADDR,
   input  logic [DBITS-1:0]      CDIN,
   output logic                  CGNT,
   output logic                  CSTALL,
   output logic                  CRVALID,
   output logic [DBITS-1:0]      CDOUT,
   input  logic                  DREQ,
   input  logic                  DWE,
   input  logic [ABITS-1:0]      DADDR,
   input  logic [BURST_BITS-1:0] DLEN,
   input  logic [DBITS-1:0]      DDIN,
   output logic                  DGNT,
   output logic                  DRVALID,
   output logic [DBITS-1:0]      DDOUT,
   output logic                  DDONE,
   output logic [ABITS-1:0]      MADDR,
   output logic [DBITS-1:0]      MDIN,
   output logic                  MWE,
   input  logic [DBITS-1:0]      MDOUT
);
   state_t state, state_nx;
   logic idle, cgnt, dgnt, load, dir, force_d, last;
   logic crvalid_q, drvalid_q, done_q;
   logic [ABITS-1:0] burst_addr;

   assign idle = state == ST_IDLE;

`ifdef DMEM_ARB_STARVE_GUARD_EN
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   logic [SW-1:0] starve;
   // count IDLE cycles the loader loses to the CPU; saturates at the limit
   always_ff @(posedge CLK or posedge RESET)
      if (RESET) starve <= '0;
      else if (dgnt) starve <= '0;
      else if (idle && DREQ && starve != SW'(STARVE_LIMIT)) starve <= starve + 1'b1;
   assign force_d = starve == SW'(STARVE_LIMIT);
`else
   assign force_d = 1'b0;
`endif

   dmem_burst_ctr #(.ABITS(ABITS), .BURST_BITS(BURST_BITS)) u_ctr (
      .clk(CLK), .rst(RESET), .load(load), .step(dgnt && !idle),
      .base(DADDR), .len(DLEN), .addr(burst_addr), .last(last)
   );

   // grant selection and port mux; bursts own the port until their last beat
   always_comb begin
      state_nx = state;
      cgnt     = 1'b0;
      dgnt     = 1'b0;
      load     = 1'b0;
      MADDR    = '0;
      MWE      = 1'b0;
      MDIN     = '0;
      if (!RESET) begin
         if (!idle) begin
            dgnt  = 1'b1;
            MADDR = burst_addr;
            MWE   = dir;
            MDIN  = dir ? DDIN : '0;
            if (last) state_nx = ST_IDLE;
         end else if (CREQ && !(force_d && DREQ)) begin
            cgnt  = 1'b1;
            MADDR = CADDR;
            MWE   = CWE;
            MDIN  = CWE ? CDIN : '0;
         end else if (DREQ) begin
            dgnt  = 1'b1;
            load  = 1'b1;
            MADDR = DADDR;
            MWE   = DWE;
            MDIN  = DWE ? DDIN : '0;
            if (DLEN != '0) state_nx = ST_BURST;
         end
      end
   end

   // state, burst direction and one-cycle-delayed read/done flags
   always_ff @(posedge CLK or posedge RESET)
      if (RESET) begin
         state     <= ST_IDLE;
         dir       <= 1'b0;
         crvalid_q <= 1'b0;
         drvalid_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state     <= state_nx;
         if (load) dir <= DWE;
         crvalid_q <= cgnt && !CWE;
         drvalid_q <= dgnt && !MWE;
         done_q    <= dgnt && (idle ? DLEN == '0 : last);
      end

   assign CGNT    = cgnt;
   assign DGNT    = dgnt;
   assign CSTALL  = !RESET && CREQ && !cgnt;
   assign CRVALID = crvalid_q;
   assign DRVALID = drvalid_q;
   assign DDONE   = done_q;
   assign CDOUT   = crvalid_q ? MDOUT : '0;
   assign DDOUT   = drvalid_q ? MDOUT : '0;
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: directed and randomized checks of the data-memory port arbiter against a memory-image model
module tb_dmem_port_arbiter;
   logic        CLK = 1'b0;
   logic        RESET;
   logic        CREQ, CWE, DREQ, DWE;
   logic [11:0] CADDR, DADDR;
   logic [15:0] CDIN, DDIN;
   logic [3:0]  DLEN;
   logic        CGNT, CSTALL, CRVALID, DGNT, DRVALID, DDONE, MWE;
   logic [15:0] CDOUT, DDOUT, MDIN;
   logic [15:0] MDOUT;
   logic [11:0] MADDR;
   logic [15:0] mem [4096];
   logic [15:0] ref_mem [4096];
   logic        mem_init;
   int          checks = 0;
   int          failures = 0;

   dmem_port_arbiter dut (
      .CLK(CLK), .RESET(RESET), .CREQ(CREQ), .CWE(CWE), .CADDR(CADDR), .CDIN(CDIN),
      .CGNT(CGNT), .CSTALL(CSTALL), .CRVALID(CRVALID), .CDOUT(CDOUT),
      .DREQ(DREQ), .DWE(DWE), .DADDR(DADDR), .DLEN(DLEN), .DDIN(DDIN),
      .DGNT(DGNT), .DRVALID(DRVALID), .DDOUT(DDOUT), .DDONE(DDONE),
      .MADDR(MADDR), .MDIN(MDIN), .MWE(MWE), .MDOUT(MDOUT)
   );

   always #5 CLK = ~CLK;

   // MemArray stand-in: synchronous write, one-cycle read latency
   always @(posedge CLK) begin
      if (mem_init) for (int i = 0; i < 4096; i++) mem[i] <= 16'(i * 7 + 16'h1234);
      else if (MWE) mem[MADDR] <= MDIN;
      MDOUT <= mem[MADDR];
   end

   initial begin
      #1000000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      logic [15:0] wd;
      logic [11:0] a, base, prev;
      logic        w;
      int          len, first, bad;
      for (int i = 0; i < 4096; i++) ref_mem[i] = 16'(i * 7 + 16'h1234);
      RESET = 1'b1; mem_init = 1'b1;
      CREQ = 0; CWE = 0; CADDR = 0; CDIN = 0; DREQ = 0; DWE = 0; DADDR = 0; DLEN = 0; DDIN = 0;
      @(posedge CLK); #1;
      mem_init = 1'b0;
      CREQ = 1; DREQ = 1; CADDR = 12'h100; DADDR = 12'h200; DWE = 1; CWE = 1;
      #1;
      chk("rst_cgnt", CGNT, 0); chk("rst_cstall", CSTALL, 0); chk("rst_dgnt", DGNT, 0);
      chk("rst_mwe", MWE, 0); chk("rst_maddr", MADDR, 0); chk("rst_crvalid", CRVALID, 0);
      chk("rst_ddone", DDONE, 0);
      CREQ = 0; DREQ = 0; RESET = 0;

      tick();
      CREQ = 1; CWE = 0; CADDR = 12'h100;
      #1;
      chk("cpu_rd_cgnt", CGNT, 1); chk("cpu_rd_maddr", MADDR, 12'h100);
      chk("cpu_rd_mwe", MWE, 0); chk("cpu_rd_cstall", CSTALL, 0);
      tick(); CREQ = 0; #1;
      chk("cpu_rd_crvalid", CRVALID, 1); chk("cpu_rd_cdout", CDOUT, ref_mem[12'h100]);

      tick();
      DREQ = 1; DWE = 1; DADDR = 12'hFFE; DLEN = 3;
      for (int i = 0; i < 4; i++) begin
         wd = 16'($urandom); DDIN = wd; a = 12'hFFE + 12'(i);
         #1;
         chk("wrap_dgnt", DGNT, 1); chk("wrap_maddr", MADDR, a);
         chk("wrap_mwe", MWE, 1); chk("wrap_mdin", MDIN, wd);
         ref_mem[a] = wd;
         tick(); DREQ = 0;
      end
      #1;
      chk("wrap_ddone", DDONE, 1); chk("wrap_idle_dgnt", DGNT, 0);
      tick(); #1;
      chk("wrap_ddone_pulse", DDONE, 0);
      chk("wrap_mem_000", mem[12'h000], ref_mem[12'h000]);
      chk("wrap_mem_ffe", mem[12'hFFE], ref_mem[12'hFFE]);

      tick();
      wd = 16'($urandom);
      CREQ = 1; CWE = 1; CADDR = 12'h200; CDIN = wd;
      DREQ = 1; DWE = 0; DADDR = 12'h300; DLEN = 0;
      #1;
      chk("both_cgnt", CGNT, 1); chk("both_dgnt", DGNT, 0);
      chk("both_maddr", MADDR, 12'h200); chk("both_mdin", MDIN, wd);
      ref_mem[12'h200] = wd;
      tick(); CREQ = 0; #1;
      chk("both_late_dgnt", DGNT, 1); chk("both_late_cgnt", CGNT, 0);
      chk("both_late_maddr", MADDR, 12'h300); chk("both_late_mwe", MWE, 0);
      tick(); DREQ = 0; #1;
      chk("both_drvalid", DRVALID, 1); chk("both_ddout", DDOUT, ref_mem[12'h300]);
      chk("both_ddone", DDONE, 1);

      tick();
      DREQ = 1; DWE = 0; DADDR = 12'h400; DLEN = 5;
      #1;
      chk("stall_beat0", DGNT, 1);
      for (int i = 1; i <= 5; i++) begin
         tick(); DREQ = 0; CREQ = 1; CWE = 0; CADDR = 12'h123;
         #1;
         chk("stall_cstall", CSTALL, 1); chk("stall_cgnt", CGNT, 0);
         chk("stall_maddr", MADDR, 12'h400 + 12'(i));
         chk("stall_drvalid", DRVALID, 1); chk("stall_ddout", DDOUT, ref_mem[12'h400 + 12'(i - 1)]);
      end
      tick(); #1;
      chk("stall_end_cgnt", CGNT, 1); chk("stall_end_cstall", CSTALL, 0);
      chk("stall_end_maddr", MADDR, 12'h123); chk("stall_end_ddone", DDONE, 1);
      chk("stall_end_ddout", DDOUT, ref_mem[12'h405]);
      tick(); CREQ = 0; #1;
      chk("stall_cpu_crvalid", CRVALID, 1); chk("stall_cpu_cdout", CDOUT, ref_mem[12'h123]);

      tick();
      DREQ = 1; DWE = 1; DADDR = 12'h500; DLEN = 7;
      for (int i = 0; i < 3; i++) begin
         wd = 16'($urandom); DDIN = wd;
         #1;
         chk("abort_maddr", MADDR, 12'h500 + 12'(i));
         if (i < 2) begin
            ref_mem[12'h500 + 12'(i)] = wd;
            tick(); DREQ = 0;
         end
      end
      RESET = 1; #1;
      chk("abort_mwe", MWE, 0); chk("abort_dgnt", DGNT, 0); chk("abort_cstall", CSTALL, 0);
      tick(); tick(); RESET = 0;
      for (int i = 0; i < 3; i++) begin
         tick(); #1;
         chk("abort_no_dgnt", DGNT, 0); chk("abort_no_ddone", DDONE, 0); chk("abort_no_mwe", MWE, 0);
      end
      chk("abort_mem_501", mem[12'h501], ref_mem[12'h501]);
      chk("abort_mem_502", mem[12'h502], ref_mem[12'h502]);
      tick();
      DREQ = 1; DWE = 1; DADDR = 12'h600; DLEN = 1;
      for (int i = 0; i < 2; i++) begin
         wd = 16'($urandom); DDIN = wd;
         #1;
         chk("restart_dgnt", DGNT, 1); chk("restart_maddr", MADDR, 12'h600 + 12'(i));
         ref_mem[12'h600 + 12'(i)] = wd;
         tick(); DREQ = 0;
      end
      #1;
      chk("restart_ddone", DDONE, 1);

      tick();
      CREQ = 1; CWE = 0; CADDR = 12'h050;
      DREQ = 1; DWE = 0; DADDR = 12'h060; DLEN = 0;
      first = -1;
      for (int i = 0; i < 40; i++) begin
         #1;
         if (DGNT === 1'b1 && first < 0) first = i;
         @(posedge CLK); #1;
         if (first >= 0) DREQ = 0;
      end
`ifdef DMEM_ARB_STARVE_GUARD_EN
      chk("starve_first_dgnt", first, 8);
      CREQ = 0; #1;
      chk("starve_release", DGNT, 0);
`else
      chk("starve_first_dgnt", first, -1);
      CREQ = 0; #1;
      chk("starve_release", DGNT, 1);
`endif
      tick(); DREQ = 0;
      tick();

      for (int t = 0; t < 40; t++) begin
         tick();
         if ($urandom_range(1, 0) == 1) begin
            a = 12'($urandom); w = 1'($urandom_range(1, 0)); wd = 16'($urandom);
            CREQ = 1; CWE = w; CADDR = a; CDIN = wd;
            #1;
            chk("rnd_cpu_cgnt", CGNT, 1); chk("rnd_cpu_maddr", MADDR, a); chk("rnd_cpu_mwe", MWE, w);
            if (w) ref_mem[a] = wd;
            tick(); CREQ = 0; #1;
            if (!w) chk("rnd_cpu_cdout", CDOUT, ref_mem[a]);
         end else begin
            base = 12'($urandom); len = $urandom_range(15, 0); w = 1'($urandom_range(1, 0));
            DREQ = 1; DWE = w; DADDR = base; DLEN = 4'(len);
            prev = base;
            for (int i = 0; i <= len; i++) begin
               a = base + 12'(i); wd = 16'($urandom); DDIN = wd;
               if (i > 0) begin
                  CREQ = 1'($urandom_range(1, 0)); CWE = 0; CADDR = 12'($urandom);
               end
               #1;
               chk("rnd_ld_dgnt", DGNT, 1); chk("rnd_ld_maddr", MADDR, a); chk("rnd_ld_mwe", MWE, w);
               if (i > 0) chk("rnd_ld_cstall", CSTALL, CREQ);
               if (w) ref_mem[a] = wd;
               else if (i > 0) chk("rnd_ld_ddout", DDOUT, ref_mem[prev]);
               prev = a;
               tick(); DREQ = 0;
            end
            CREQ = 0; #1;
            chk("rnd_ld_ddone", DDONE, 1);
            if (!w) chk("rnd_ld_ddout_last", DDOUT, ref_mem[prev]);
         end
      end

      tick(); tick();
      bad = 0;
      for (int i = 0; i < 4096; i++) if (mem[i] !== ref_mem[i]) bad++;
      chk("mem_image", bad, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
